// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: the {pc, instr} bundle handed from fetch to decode.
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry shift FIFO of fetch entries; entry 0 is always the head.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t e0;
    fetch_entry_t e1;
    logic [1:0]   cnt;

    assign head  = e0;
    assign count = cnt;

    // Flush only drops the count so the head value keeps showing on out_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 2'd0;
            e0  <= '0;
            e1  <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else if (push && pop) begin
            if (cnt == 2'd2) begin
                e0 <= e1;
                e1 <= din;
            end else begin
                e0 <= din;
            end
        end else if (push) begin
            if (cnt == 2'd0) begin
                e0 <= din;
            end else begin
                e1 <= din;
            end
            cnt <= cnt + 2'd1;
        end else if (pop) begin
            if (cnt == 2'd2) begin
                e0 <= e1;
            end
            cnt <= cnt - 2'd1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, ROM addressing, redirect/flush, misalignment fault.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int              AW       = 10,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic [AW-1:0]      rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic               fetch_fault
);

    logic [XLEN-1:0] pc;
    logic            fault;
    logic            aligned;
    logic            pop;
    logic            push;
    logic [1:0]      count;
    fetch_entry_t    din;
    fetch_entry_t    head;

    assign aligned  = (pc[1:0] == 2'b00);
    assign rom_addr = pc[AW+1:2];
    assign din      = '{pc: pc, instr: rom_data};

    assign out_valid   = (count != 2'd0);
    assign out_instr   = head.instr;
    assign out_pc      = head.pc;
    assign fetch_fault = fault;

    assign pop  = out_valid && out_ready;
    // A misaligned pc is blocked even in the cycle before the fault flag rises.
    assign push = fetch_en && !fault && aligned && !redirect_valid
               && (count != 2'd2 || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc;
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else if (redirect_valid && redirect_pc[1:0] == 2'b00) begin
            fault <= 1'b0;
        end else if (!aligned) begin
            fault <= 1'b1;
        end
    end

    fetch_buffer u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a queue-based scoreboard on the output handshake.
module tb_instr_fetch;
    import fetch_pkg::*;

    localparam int AW = 10;

    logic          clk;
    logic          rst_n;
    logic          fetch_en;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic          fetch_fault;

    int checks   = 0;
    int failures = 0;

    fetch_entry_t exp_q[$];

    instr_fetch #(.AW(AW), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
    );

    // Bench ROM image: word[i] = 0x1000_0000 | i
    assign rom_data = 32'h1000_0000 | {22'd0, rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_emit pc=%h instr=%h required no output",
                         out_pc, out_instr);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    failures++;
                    $display("FAIL emit pc=%h instr=%h required pc=%h instr=%h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_out(input logic [31:0] p, input logic [31:0] i);
        exp_q.push_back('{pc: p, instr: i});
    endtask

    task automatic apply_reset(input logic fe, input logic rdy);
        rst_n          = 1'b0;
        fetch_en       = fe;
        out_ready      = rdy;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain actual=%0d pending required=0", name,
                     exp_q.size());
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_addr", {22'd0, rom_addr}, 32'd0);

        // 1: streaming at one instruction per cycle
        apply_reset(1'b1, 1'b1);
        expect_out(32'h0, 32'h1000_0000);
        expect_out(32'h4, 32'h1000_0001);
        expect_out(32'h8, 32'h1000_0002);
        chk("t1_valid_pre", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t1_valid_c1", {31'd0, out_valid}, 32'd1);
        tick();
        chk("t1_valid_c2", {31'd0, out_valid}, 32'd1);
        tick();
        chk("t1_valid_c3", {31'd0, out_valid}, 32'd1);
        fetch_en = 1'b0;
        drain("t1");

        // 2: backpressure saturates the buffer
        apply_reset(1'b1, 1'b0);
        repeat (5) tick();
        chk("t2_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_addr", {22'd0, rom_addr}, 32'd2);
        chk("t2_head_pc", out_pc, 32'h0);
        expect_out(32'h0, 32'h1000_0000);
        expect_out(32'h4, 32'h1000_0001);
        expect_out(32'h8, 32'h1000_0002);
        out_ready = 1'b1;
        tick();
        fetch_en = 1'b0;
        drain("t2");

        // 3: redirect flushes a full buffer
        apply_reset(1'b1, 1'b0);
        repeat (3) tick();
        chk("t3_full_valid", {31'd0, out_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        chk("t3_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("t3_addr", {22'd0, rom_addr}, 32'h10);
        expect_out(32'h40, 32'h1000_0010);
        tick();
        chk("t3_valid", {31'd0, out_valid}, 32'd1);
        fetch_en = 1'b0;
        drain("t3");

        // 4: misaligned redirect faults, aligned redirect recovers
        apply_reset(1'b0, 1'b1);
        fetch_en       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        redirect_valid = 1'b0;
        chk("t4_fault_pre", {31'd0, fetch_fault}, 32'd0);
        chk("t4_valid_pre", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t4_fault_set", {31'd0, fetch_fault}, 32'd1);
        chk("t4_valid_set", {31'd0, out_valid}, 32'd0);
        repeat (3) tick();
        chk("t4_fault_hold", {31'd0, fetch_fault}, 32'd1);
        chk("t4_valid_hold", {31'd0, out_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        redirect_valid = 1'b0;
        chk("t4_fault_clr", {31'd0, fetch_fault}, 32'd0);
        expect_out(32'h80, 32'h1000_0020);
        tick();
        chk("t4_valid", {31'd0, out_valid}, 32'd1);
        fetch_en = 1'b0;
        drain("t4");

        // 5: rom_addr aliasing and 32-bit pc wrap
        apply_reset(1'b0, 1'b1);
        expect_out(32'hFFC, 32'h1000_03FF);
        expect_out(32'h1000, 32'h1000_0000);
        fetch_en       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFC;
        tick();
        redirect_valid = 1'b0;
        chk("t5_addr_top", {22'd0, rom_addr}, 32'h3FF);
        tick();
        chk("t5_addr_wrap", {22'd0, rom_addr}, 32'h0);
        tick();
        fetch_en = 1'b0;
        drain("t5a");
        expect_out(32'hFFFF_FFFC, 32'h1000_03FF);
        expect_out(32'h0, 32'h1000_0000);
        fetch_en       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        fetch_en = 1'b0;
        drain("t5b");

        // 6: asynchronous reset with a full buffer
        apply_reset(1'b1, 1'b0);
        repeat (3) tick();
        chk("t6_addr_pre", {22'd0, rom_addr}, 32'd2);
        chk("t6_valid_pre", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid_rst", {31'd0, out_valid}, 32'd0);
        chk("t6_addr_rst", {22'd0, rom_addr}, 32'd0);
        chk("t6_pc_rst", out_pc, 32'h0);
        chk("t6_instr_rst", out_instr, 32'h0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        expect_out(32'h0, 32'h1000_0000);
        expect_out(32'h4, 32'h1000_0001);
        tick();
        tick();
        fetch_en = 1'b0;
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
